// File: rtl/block_painter_pkg.sv
// Shared types and helpers for the block painter: pixel/coordinate types, the pass
// state encoding, the address-width check and the first-live-square search.
package block_painter_pkg;

  typedef logic [15:0] pixel_t;
  typedef logic [6:0]  coord_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } paint_state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } sq_sel_t;

  localparam int unsigned SCREEN_H     = 480;
  localparam int unsigned DEF_SCREEN_W = 640;
  localparam int unsigned DEF_ADDR_W   = 19;

  function automatic bit addr_w_fits(input int unsigned screen_w, input int unsigned addr_w);
    return (64'(screen_w) * 64'(SCREEN_H)) <= (64'd1 << addr_w);
  endfunction

  localparam bit ADDR_W_OK = addr_w_fits(DEF_SCREEN_W, DEF_ADDR_W);

  // Lowest square index >= from whose keep bit is set; found=0 when none remain.
  function automatic sq_sel_t first_square(input logic [3:0] keep, input logic [2:0] from);
    sq_sel_t sel;
    sel.found = 1'b0;
    sel.idx   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (keep[k] && (3'(k) >= from)) begin
        sel.found = 1'b1;
        sel.idx   = 2'(k);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/block_painter_if.sv
// Frame-buffer pixel write port: one pixel per fb_we/fb_ready handshake.
interface block_painter_if #(
  parameter int ADDR_W = 19
);
  import block_painter_pkg::*;

  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  pixel_t            fb_data;
  logic              fb_ready;

  modport master (output fb_we, fb_addr, fb_data, input fb_ready);
  modport slave  (input fb_we, fb_addr, fb_data, output fb_ready);

endinterface

// File: rtl/block_painter_square_scan.sv
// Row-major pixel counters for one square; exposes the position the next cycle will hold
// so the owner can register the matching address.
module square_scan #(
  parameter int SQ_PX = 16,
  parameter int PW    = $clog2(SQ_PX)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          clear,
  input  logic          advance,
  output logic [PW-1:0] px_next,
  output logic [PW-1:0] py_next,
  output logic          last_px
);

  localparam logic [PW-1:0] PMAX = PW'(SQ_PX - 1);

  logic [PW-1:0] px;
  logic [PW-1:0] py;

  assign last_px = (px == PMAX) && (py == PMAX);

  // Next scan position: clear wins, otherwise step row-major on each accepted pixel.
  always_comb begin
    px_next = px;
    py_next = py;
    if (clear) begin
      px_next = '0;
      py_next = '0;
    end else if (advance) begin
      if (px == PMAX) begin
        px_next = '0;
        py_next = py + PW'(1);
      end else begin
        px_next = px + PW'(1);
      end
    end else begin
      px_next = px;
      py_next = py;
    end
  end

  // Counter registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      px <= '0;
      py <= '0;
    end else begin
      px <= px_next;
      py <= py_next;
    end
  end

endmodule

// File: rtl/block_painter.sv
// Consumer of game-logic piece updates: snapshots the move, erases the old squares with
// the background colour and draws the new ones, one handshaked pixel per accepted write.
module block_painter
  import block_painter_pkg::*;
#(
  parameter int     SQ_PX    = 16,
  parameter int     BOARD_X0 = 200,
  parameter int     BOARD_Y0 = 80,
  parameter int     SCREEN_W = DEF_SCREEN_W,
  parameter int     BOARD_W  = 9,
  parameter int     BOARD_H  = 19,
  parameter pixel_t BG_COLOR = 16'h0000,
  parameter int     ADDR_W   = DEF_ADDR_W
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            update,
  input  logic            prev_valid,
  input  coord_t [3:0]    blockXPos,
  input  coord_t [3:0]    blockYPos,
  input  coord_t [3:0]    blockXPrev,
  input  coord_t [3:0]    blockYPrev,
  input  pixel_t          blockColor,
  block_painter_if.master fb,
  output logic            busy,
  output logic            done,
  output logic            overrun
);

  localparam int PW = $clog2(SQ_PX);

  paint_state_t      state, nxt_state, req_pass, res_state;
  logic [1:0]        sq_idx, nxt_idx, res_idx;
  logic [2:0]        req_from;
  sq_sel_t           era_sel, drw_sel;
  coord_t [3:0]      snap_x, snap_y, snap_xp, snap_yp;
  coord_t [3:0]      src_x, src_y, src_xp, src_yp;
  pixel_t            snap_color, src_color;
  logic [3:0]        erase_keep, draw_keep;
  logic              start_sq, in_pass, nxt_in_pass, last_px;
  logic [PW-1:0]     px_next, py_next;
  coord_t            pix_x, pix_y;
  logic [ADDR_W-1:0] row, col, pix_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  pixel_t            wr_data;

  function automatic logic in_board(input coord_t x, input coord_t y);
    return (x <= coord_t'(BOARD_W)) && (y <= coord_t'(BOARD_H));
  endfunction

  assign in_pass     = (state == ERASE) || (state == DRAW);
  assign nxt_in_pass = (nxt_state == ERASE) || (nxt_state == DRAW);

  assign fb.fb_we   = wr_en;
  assign fb.fb_addr = wr_addr;
  assign fb.fb_data = wr_data;

  // In IDLE the live inputs stand in for the snapshot so skips resolve on the update edge.
  always_comb begin
    if (state == IDLE) begin
      src_x     = blockXPos;
      src_y     = blockYPos;
      src_xp    = blockXPrev;
      src_yp    = blockYPrev;
      src_color = blockColor;
    end else begin
      src_x     = snap_x;
      src_y     = snap_y;
      src_xp    = snap_xp;
      src_yp    = snap_yp;
      src_color = snap_color;
    end
  end

  // Per-square keep masks: an old square is erased only if off-board squares and squares
  // the piece still covers are excluded; a new square is drawn whenever it is on the board.
  always_comb begin
    erase_keep = 4'b0000;
    draw_keep  = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      draw_keep[k]  = in_board(src_x[k], src_y[k]);
      erase_keep[k] = in_board(src_xp[k], src_yp[k]);
      for (int j = 0; j < 4; j++) begin
        erase_keep[k] = erase_keep[k] &
                        ~((src_xp[k] == src_x[j]) && (src_yp[k] == src_y[j]));
      end
    end
  end

  assign req_pass = (state == IDLE) ? (prev_valid ? ERASE : DRAW) : state;
  assign req_from = (state == IDLE) ? 3'd0 : ({1'b0, sq_idx} + 3'd1);
  assign era_sel  = first_square(erase_keep, req_from);
  assign drw_sel  = first_square(draw_keep, (req_pass == ERASE) ? 3'd0 : req_from);

  // Where the scan lands when a square starts; empty passes chain through in the same cycle.
  always_comb begin
    if ((req_pass == ERASE) && era_sel.found) begin
      res_state = ERASE;
      res_idx   = era_sel.idx;
    end else if (drw_sel.found) begin
      res_state = DRAW;
      res_idx   = drw_sel.idx;
    end else begin
      res_state = DONE;
      res_idx   = 2'd0;
    end
  end

  // FSM next state and square index.
  always_comb begin
    nxt_state = state;
    nxt_idx   = sq_idx;
    start_sq  = 1'b0;
    case (state)
      IDLE: begin
        if (update) begin
          start_sq  = 1'b1;
          nxt_state = res_state;
          nxt_idx   = res_idx;
        end else begin
          nxt_state = IDLE;
        end
      end
      ERASE, DRAW: begin
        if (fb.fb_ready && last_px) begin
          start_sq  = 1'b1;
          nxt_state = res_state;
          nxt_idx   = res_idx;
        end else begin
          nxt_state = state;
        end
      end
      DONE: begin
        nxt_state = IDLE;
        nxt_idx   = 2'd0;
      end
      default: begin
        nxt_state = IDLE;
        nxt_idx   = 2'd0;
      end
    endcase
  end

  square_scan #(
    .SQ_PX (SQ_PX),
    .PW    (PW)
  ) u_scan (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .clear   (start_sq | ~in_pass),
    .advance (in_pass & fb.fb_ready),
    .px_next (px_next),
    .py_next (py_next),
    .last_px (last_px)
  );

  // Address of the pixel presented next cycle; ADDR_W-bit wrap equals truncating the exact value.
  always_comb begin
    if (nxt_state == ERASE) begin
      pix_x = src_xp[nxt_idx];
      pix_y = src_yp[nxt_idx];
    end else begin
      pix_x = src_x[nxt_idx];
      pix_y = src_y[nxt_idx];
    end
    row      = ADDR_W'(BOARD_Y0) + (ADDR_W'(pix_y) << PW) + ADDR_W'(py_next);
    col      = ADDR_W'(BOARD_X0) + (ADDR_W'(pix_x) << PW) + ADDR_W'(px_next);
    pix_addr = row * ADDR_W'(SCREEN_W) + col;
  end

  // State, square index and registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      sq_idx  <= 2'd0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= 16'h0000;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= nxt_state;
      sq_idx  <= nxt_idx;
      wr_en   <= nxt_in_pass;
      busy    <= nxt_in_pass;
      done    <= (nxt_state == DONE);
      wr_addr <= nxt_in_pass ? pix_addr : '0;
      wr_data <= (nxt_state == ERASE) ? BG_COLOR :
                 ((nxt_state == DRAW) ? src_color : 16'h0000);
      if (update && (state != IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

  // Snapshot of the accepted update.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      snap_x     <= '0;
      snap_y     <= '0;
      snap_xp    <= '0;
      snap_yp    <= '0;
      snap_color <= 16'h0000;
    end else if ((state == IDLE) && update) begin
      snap_x     <= blockXPos;
      snap_y     <= blockYPos;
      snap_xp    <= blockXPrev;
      snap_yp    <= blockYPrev;
      snap_color <= blockColor;
    end
  end

endmodule

// File: tb/tb_block_painter.sv
// Directed bench for block_painter: a scoreboard queue holds every expected pixel write,
// filled from a reference model when an update is issued and drained as writes are accepted.
`timescale 1ns/1ps
module tb_block_painter;
  import block_painter_pkg::*;

  typedef struct packed {
    logic [18:0] addr;
    logic [15:0] data;
  } wr_t;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic         update = 1'b0;
  logic         prev_valid = 1'b0;
  coord_t [3:0] blockXPos = '0;
  coord_t [3:0] blockYPos = '0;
  coord_t [3:0] blockXPrev = '0;
  coord_t [3:0] blockYPrev = '0;
  pixel_t       blockColor = 16'h0000;
  logic         busy, done, overrun;

  int  checks = 0;
  int  errors = 0;
  int  wr_count = 0;
  int  first_addr = -1;
  bit  stall_mode = 1'b0;
  wr_t exp_q[$];
  wr_t got_w, exp_w;
  bit  hold_prev = 1'b0;
  logic [18:0] hold_addr;
  logic [15:0] hold_data;

  block_painter_if #(.ADDR_W(19)) fb_bus ();

  block_painter dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .update     (update),
    .prev_valid (prev_valid),
    .blockXPos  (blockXPos),
    .blockYPos  (blockYPos),
    .blockXPrev (blockXPrev),
    .blockYPrev (blockYPrev),
    .blockColor (blockColor),
    .fb         (fb_bus),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  always #5 Clk = ~Clk;

  // fb_ready: always 1, or the stall pattern 1,0,0,1 repeating.
  initial begin
    int ph;
    ph = 0;
    fb_bus.fb_ready = 1'b1;
    forever begin
      @(posedge Clk);
      #1;
      if (stall_mode) begin
        fb_bus.fb_ready = (ph == 0) || (ph == 3);
        ph = (ph + 1) % 4;
      end else begin
        fb_bus.fb_ready = 1'b1;
        ph = 0;
      end
    end
  end

  // Write monitor: scoreboard compare on accepted writes, stability check across stalls.
  always @(negedge Clk) begin
    if (Reset_n && fb_bus.fb_we && fb_bus.fb_ready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL wr_unexpected addr %0d data %h with empty scoreboard", fb_bus.fb_addr, fb_bus.fb_data);
      end
      if (exp_q.size() > 0) begin
        got_w.addr = fb_bus.fb_addr;
        got_w.data = fb_bus.fb_data;
        exp_w = exp_q.pop_front();
        checks++;
        assert (got_w === exp_w) else begin
          errors++;
          $error("FAIL wr%0d got addr %0d data %h expected addr %0d data %h",
                 wr_count, got_w.addr, got_w.data, exp_w.addr, exp_w.data);
        end
      end
      if (wr_count == 0) first_addr = int'(fb_bus.fb_addr);
      wr_count++;
    end
    if (Reset_n && hold_prev) begin
      checks++;
      assert (fb_bus.fb_we === 1'b1 && fb_bus.fb_addr === hold_addr && fb_bus.fb_data === hold_data) else begin
        errors++;
        $error("FAIL stall_hold got we %b addr %0d data %h expected we 1 addr %0d data %h",
               fb_bus.fb_we, fb_bus.fb_addr, fb_bus.fb_data, hold_addr, hold_data);
      end
    end
    hold_prev = Reset_n && fb_bus.fb_we && !fb_bus.fb_ready;
    hold_addr = fb_bus.fb_addr;
    hold_data = fb_bus.fb_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, expv);
    end
  endtask

  function automatic logic [27:0] sq4(input int a0, input int a1, input int a2, input int a3);
    return {7'(a3), 7'(a2), 7'(a1), 7'(a0)};
  endfunction

  task automatic push_square(input coord_t x, input coord_t y, input pixel_t c, inout int n);
    int a;
    for (int py = 0; py < 16; py++) begin
      for (int px = 0; px < 16; px++) begin
        a = (80 + int'(y) * 16 + py) * 640 + 200 + int'(x) * 16 + px;
        exp_q.push_back('{addr: a[18:0], data: c});
        n++;
      end
    end
  endtask

  // Reference model of one update: erase pass then draw pass, skip rules applied.
  task automatic model_push(input logic pv, input coord_t [3:0] xs, input coord_t [3:0] ys,
                            input coord_t [3:0] xps, input coord_t [3:0] yps,
                            input pixel_t col, output int n);
    bit skip;
    n = 0;
    if (pv) begin
      for (int k = 0; k < 4; k++) begin
        skip = (xps[k] > 7'd9) || (yps[k] > 7'd19);
        for (int j = 0; j < 4; j++) begin
          if (xps[k] == xs[j] && yps[k] == ys[j]) skip = 1'b1;
        end
        if (!skip) push_square(xps[k], yps[k], 16'h0000, n);
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (xs[k] <= 7'd9 && ys[k] <= 7'd19) push_square(xs[k], ys[k], col, n);
    end
  endtask

  task automatic pulse_update(input logic pv, input coord_t [3:0] xs, input coord_t [3:0] ys,
                              input coord_t [3:0] xps, input coord_t [3:0] yps, input pixel_t col);
    prev_valid = pv;
    blockXPos  = xs;
    blockYPos  = ys;
    blockXPrev = xps;
    blockYPrev = yps;
    blockColor = col;
    update     = 1'b1;
    @(posedge Clk);
    #1;
    update = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (done !== 1'b1 && n < 20000) begin
      @(posedge Clk);
      #1;
      n++;
    end
    checks++;
    assert (done === 1'b1) else begin
      errors++;
      $error("FAIL done_timeout got done %b after %0d cycles expected 1", done, n);
    end
  endtask

  task automatic run_case(input string tag, input logic pv, input coord_t [3:0] xs, input coord_t [3:0] ys,
                          input coord_t [3:0] xps, input coord_t [3:0] yps, input pixel_t col, input bit chk_lat);
    int n_exp, n;
    exp_q.delete();
    wr_count   = 0;
    first_addr = -1;
    model_push(pv, xs, ys, xps, yps, col, n_exp);
    pulse_update(pv, xs, ys, xps, yps, col);
    if (n_exp > 0) check({tag, "_busy"}, busy, 1);
    wait_done(n);
    if (chk_lat) check({tag, "_latency"}, n, n_exp + 1);
    check({tag, "_writes"}, wr_count, n_exp);
    check({tag, "_leftover"}, exp_q.size(), 0);
    check({tag, "_done_busy"}, busy, 0);
    @(posedge Clk);
    #1;
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    coord_t [3:0] sx, sy, mx, my, zx, ox, oy, nx, ny, fx;
    int n;
    sx = sq4(4, 5, 5, 6);   sy = sq4(0, 0, 1, 1);
    mx = sx;                my = sq4(1, 1, 2, 2);
    zx = '0;
    ox = sq4(10, 0, 9, 3);  oy = sq4(3, 0, 19, 20);
    nx = sq4(2, 0, 7, 8);   ny = sq4(2, 0, 7, 8);
    fx = sq4(10, 10, 10, 10);

    repeat (3) @(posedge Clk);
    #1;
    check("rst_we", fb_bus.fb_we, 0);
    check("rst_addr", fb_bus.fb_addr, 0);
    check("rst_data", fb_bus.fb_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    run_case("spawn", 1'b0, sx, sy, zx, zx, 16'h0f00, 1'b1);
    check("spawn_first_addr", first_addr, 51464);
    run_case("move_down", 1'b1, mx, my, sx, sy, 16'h0f00, 1'b1);

    stall_mode = 1'b1;
    run_case("stall", 1'b1, mx, my, sx, sy, 16'h0f00, 1'b0);
    stall_mode = 1'b0;
    @(posedge Clk);
    #1;

    // Second update mid-DRAW must not disturb the snapshot.
    exp_q.delete();
    wr_count = 0;
    model_push(1'b0, sx, sy, zx, zx, 16'h0f00, n);
    pulse_update(1'b0, sx, sy, zx, zx, 16'h0f00);
    repeat (100) begin
      @(posedge Clk);
      #1;
    end
    check("ovr_before", overrun, 0);
    pulse_update(1'b1, nx, ny, mx, my, 16'hffff);
    check("ovr_set", overrun, 1);
    wait_done(n);
    check("ovr_writes", wr_count, 1024);
    check("ovr_leftover", exp_q.size(), 0);
    check("ovr_at_done", overrun, 1);
    @(posedge Clk);
    #1;

    run_case("oor_draw", 1'b0, ox, oy, zx, zx, 16'h00f0, 1'b1);
    run_case("oor_erase", 1'b1, nx, ny, ox, oy, 16'h001f, 1'b1);
    run_case("all_skip", 1'b1, fx, ny, fx, oy, 16'h1234, 1'b1);
    check("ovr_sticky", overrun, 1);

    // Reset in the middle of a pass.
    exp_q.delete();
    wr_count = 0;
    model_push(1'b0, sx, sy, zx, zx, 16'h0f00, n);
    pulse_update(1'b0, sx, sy, zx, zx, 16'h0f00);
    n = 0;
    while (wr_count < 300 && n < 2000) begin
      @(posedge Clk);
      #1;
      n++;
    end
    check("mid_reach300", (wr_count >= 300), 1);
    #2;
    Reset_n = 1'b0;
    #1;
    check("mid_rst_we", fb_bus.fb_we, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_overrun", overrun, 0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    run_case("restart", 1'b0, sx, sy, zx, zx, 16'h0f00, 1'b1);
    check("restart_first_addr", first_addr, 51464);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
